// File: rtl/seven_segment_pkg.sv
// Shared types, constants and hex-to-segment decode for the seven-segment scheduler.
// Segment codes are active-low, bit7 = a ... bit1 = g, bit0 = h (decimal point).
package seven_segment_pkg;

    typedef logic [7:0] seg_t;

    localparam seg_t       SEG_OFF   = 8'hFF;
    localparam logic [7:0] DIGIT_OFF = 8'hFF;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } state_t;

    // Dot bit is left high here; the decoder clears it when the dot is lit.
    function automatic seg_t hex_to_seg(input logic [3:0] nibble);
        seg_t seg;
        case (nibble)
            4'h0:    seg = 8'b0000_0011;
            4'h1:    seg = 8'b1001_1111;
            4'h2:    seg = 8'b0010_0101;
            4'h3:    seg = 8'b0000_1101;
            4'h4:    seg = 8'b1001_1001;
            4'h5:    seg = 8'b0100_1001;
            4'h6:    seg = 8'b0100_0001;
            4'h7:    seg = 8'b0001_1111;
            4'h8:    seg = 8'b0000_0001;
            4'h9:    seg = 8'b0000_1001;
            4'hA:    seg = 8'b0001_0001;
            4'hB:    seg = 8'b1100_0001;
            4'hC:    seg = 8'b0110_0011;
            4'hD:    seg = 8'b1000_0101;
            4'hE:    seg = 8'b0110_0001;
            default: seg = 8'b0111_0001;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seven_segment_hex_decoder.sv
// Combinational nibble + dot to active-low abcdefgh segment pattern.
module seven_segment_hex_decoder
    import seven_segment_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dot,
    output seg_t       seg
);

    assign seg = hex_to_seg(nibble) & ~{7'b000_0000, dot};

endmodule

// File: rtl/seven_segment_scheduler.sv
// Time-multiplexed 8-digit common-anode display driver with per-slot blanking and a
// frame-boundary valid/ready update port. Optional PWM dimming: SEVEN_SEGMENT_SCHEDULER_BRIGHTNESS_EN.
module seven_segment_scheduler
    import seven_segment_pkg::*;
#(
    parameter int strobe_width = 16,
    parameter int blank_cycles = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] number,
    input  logic [7:0]  dots,
    input  logic [7:0]  digit_en,
    input  logic        update_valid,
    output logic        update_ready,
    input  logic [2:0]  brightness,
    output logic [7:0]  abcdefgh,
    output logic [7:0]  digit,
    output logic        frame_start
);

    localparam logic [strobe_width-1:0] SLOT_LAST   = '1;
    localparam logic [strobe_width-1:0] SLOT_ONE    = {{(strobe_width-1){1'b0}}, 1'b1};
    localparam logic [strobe_width-1:0] BLANK_LIMIT = blank_cycles[strobe_width-1:0];
    localparam state_t                  RESET_STATE = (blank_cycles > 0) ? BLANK : SHOW;

    logic [strobe_width-1:0] slot_cnt_reg, slot_cnt_next;
    logic [2:0]              index_reg, index_next;
    state_t                  state_reg, state_next;

    logic [31:0] shadow_number_reg;
    logic [7:0]  shadow_dots_reg;
    logic [7:0]  shadow_digit_en_reg;

    logic [7:0]  abcdefgh_reg, abcdefgh_next;
    logic [7:0]  digit_reg, digit_next;
    logic        frame_start_reg;

    logic        last_cycle;
    logic        transfer;
    logic        bright_ok;
    seg_t        dec_seg;
    logic [7:0]  digit_sel;

    assign slot_cnt_next = slot_cnt_reg + SLOT_ONE;
    assign index_next    = (slot_cnt_reg == SLOT_LAST) ? index_reg + 3'd1 : index_reg;
    assign last_cycle    = (index_reg == 3'd7) && (slot_cnt_reg == SLOT_LAST);
    assign transfer      = update_valid && last_cycle;

    // Ready is a pure decode of the counters so it never waits on valid.
    assign update_ready = last_cycle;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot_cnt_reg        <= '0;
            index_reg           <= 3'd0;
            shadow_number_reg   <= 32'd0;
            shadow_dots_reg     <= 8'd0;
            shadow_digit_en_reg <= 8'd0;
            abcdefgh_reg        <= SEG_OFF;
            digit_reg           <= DIGIT_OFF;
            frame_start_reg     <= 1'b0;
        end else begin
            slot_cnt_reg    <= slot_cnt_next;
            index_reg       <= index_next;
            abcdefgh_reg    <= abcdefgh_next;
            digit_reg       <= digit_next;
            frame_start_reg <= last_cycle;
            if (transfer) begin
                shadow_number_reg   <= number;
                shadow_dots_reg     <= dots;
                shadow_digit_en_reg <= digit_en;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= RESET_STATE;
        end else begin
            state_reg <= state_next;
        end
    end

    // The state tracks the counters it is registered alongside.
    always_comb begin
        state_next = SHOW;
        if (slot_cnt_next < BLANK_LIMIT) begin
            state_next = BLANK;
        end
    end

    seven_segment_hex_decoder u_hex_decoder (
        .nibble (shadow_number_reg[4*index_reg +: 4]),
        .dot    (shadow_dots_reg[index_reg]),
        .seg    (dec_seg)
    );

    // Disabled digits still occupy their slot so every digit keeps the same duty cycle.
    for (genvar gi = 0; gi < 8; gi++) begin : g_digit_sel
        assign digit_sel[gi] = !((index_reg == 3'(gi)) && shadow_digit_en_reg[gi]);
    end

`ifdef SEVEN_SEGMENT_SCHEDULER_BRIGHTNESS_EN
    assign bright_ok = (slot_cnt_reg[strobe_width-1 -: 3] <= brightness);
`else
    logic unused_brightness;
    assign unused_brightness = ^brightness;
    assign bright_ok         = 1'b1;
`endif

    always_comb begin
        abcdefgh_next = SEG_OFF;
        digit_next    = DIGIT_OFF;
        if ((state_reg == SHOW) && bright_ok) begin
            abcdefgh_next = dec_seg;
            digit_next    = digit_sel;
        end
    end

    assign abcdefgh    = abcdefgh_reg;
    assign digit       = digit_reg;
    assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_seven_segment_scheduler.sv
// Directed bench for seven_segment_scheduler with 8-cycle slots, 2 blank cycles, 64-cycle frames.
module tb_seven_segment_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] number = 32'd0;
    logic [7:0]  dots = 8'd0;
    logic [7:0]  digit_en = 8'd0;
    logic        update_valid = 1'b0;
    logic        update_ready;
    logic [2:0]  brightness = 3'd3;
    logic [7:0]  abcdefgh;
    logic [7:0]  digit;
    logic        frame_start;

    int checks = 0;
    int errors = 0;
    int k = 0;

    logic [31:0] exp_number = 32'd0;
    logic [7:0]  exp_dots = 8'd0;
    logic [7:0]  exp_en = 8'd0;
    logic [31:0] pend_number = 32'd0;
    logic [7:0]  pend_dots = 8'd0;
    logic [7:0]  pend_en = 8'd0;
    logic        apply_pending = 1'b0;
    logic        drop_pending = 1'b0;

    logic [7:0] seg_tab [16] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                                 8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};

    always #5 clk = ~clk;

    seven_segment_scheduler #(
        .strobe_width (3),
        .blank_cycles (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .number       (number),
        .dots         (dots),
        .digit_en     (digit_en),
        .update_valid (update_valid),
        .update_ready (update_ready),
        .brightness   (brightness),
        .abcdefgh     (abcdefgh),
        .digit        (digit),
        .frame_start  (frame_start)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, obs, exp);
        end
    endtask

    // Expected outputs at cycle k follow the counters of cycle k-1.
    task automatic check_cycle();
        int p, s, i;
        logic [3:0] nib;
        logic [7:0] es, ed;
        es = 8'hFF;
        ed = 8'hFF;
        if (k > 0) begin
            p = k - 1;
            s = p % 8;
            i = (p / 8) % 8;
            if (s >= 2) begin
                nib = exp_number[4*i +: 4];
                es  = seg_tab[nib];
                if (exp_dots[i]) es[0] = 1'b0;
                if (exp_en[i]) ed = ~(8'h01 << i);
`ifdef SEVEN_SEGMENT_SCHEDULER_BRIGHTNESS_EN
                if (s > int'(brightness)) begin
                    es = 8'hFF;
                    ed = 8'hFF;
                end
`endif
            end
        end
        chk("abcdefgh", abcdefgh, es);
        chk("digit", digit, ed);
        chk("digit_onehot", {7'd0, $countones(~digit) <= 1}, 8'h01);
        chk("update_ready", {7'd0, update_ready}, {7'd0, (k % 64) == 63});
        chk("frame_start", {7'd0, frame_start}, {7'd0, (k > 0) && ((k % 64) == 0)});
        if (apply_pending) begin
            exp_number    = pend_number;
            exp_dots      = pend_dots;
            exp_en        = pend_en;
            apply_pending = 1'b0;
        end
        if (update_valid && ((k % 64) == 63)) begin
            pend_number   = number;
            pend_dots     = dots;
            pend_en       = digit_en;
            apply_pending = 1'b1;
            drop_pending  = 1'b1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        k++;
        #1;
        if (drop_pending) begin
            update_valid = 1'b0;
            drop_pending = 1'b0;
        end
        @(negedge clk);
        check_cycle();
    endtask

    initial begin
        // Held in reset: everything dark, no handshake.
        repeat (3) begin
            @(negedge clk);
            chk("rst_abcdefgh", abcdefgh, 8'hFF);
            chk("rst_digit", digit, 8'hFF);
            chk("rst_ready", {7'd0, update_ready}, 8'h00);
            chk("rst_frame_start", {7'd0, frame_start}, 8'h00);
        end

        // First frame shows cleared shadow: segments decode 0, digits stay off.
        reset = 1'b1;
        k = 0;
        check_cycle();
        repeat (40) step();

        // Valid raised mid-frame and held; transfer only at the frame end.
        number       = 32'h7654_3210;
        digit_en     = 8'hFF;
        dots         = 8'h01;
        update_valid = 1'b1;
        repeat (34) step();

        // Second update disables digit 2 and lights the dot on digit 7.
        number       = 32'h89AB_CDEF;
        digit_en     = 8'hFB;
        dots         = 8'h80;
        update_valid = 1'b1;
        repeat (90) step();

        // k = 164: slot 3 of index 4 is being shown; reset asynchronously mid-cycle.
        #2;
        reset = 1'b0;
        #1;
        chk("async_abcdefgh", abcdefgh, 8'hFF);
        chk("async_digit", digit, 8'hFF);
        chk("async_ready", {7'd0, update_ready}, 8'h00);
        chk("async_frame_start", {7'd0, frame_start}, 8'h00);
        exp_number    = 32'd0;
        exp_dots      = 8'd0;
        exp_en        = 8'd0;
        apply_pending = 1'b0;
        drop_pending  = 1'b0;
        update_valid  = 1'b0;
        number        = 32'd0;
        digit_en      = 8'd0;
        dots          = 8'd0;

        @(negedge clk);
        reset = 1'b1;
        k = 0;
        check_cycle();
        repeat (66) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
